round_robin_mux: RTL and testbench

ROUND_ROBIN_MUX -- requirements
Module: round_robin_mux

---
 rtl/mux_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/round_robin_mux.sv | 109 ++++++++++
 tb/tb_round_robin_mux.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared helpers for mux blocks: width derivation for channel select/index signals
// and the selection-mode encoding.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Smallest r such that 2**r >= value; constant-evaluable for parameter derivation.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int sel_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester found searching upward from last_ptr+1 with wrap.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  localparam int SELW     = sel_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SELW-1:0]     last_ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SELW-1:0]     grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = int'(last_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      // Compare against each channel rather than indexing with a computed int.
      for (int c = 0; c < CHANNELS; c++) begin
        if (!found && (c == idx) && req[c]) begin
          grant[c]  = 1'b1;
          grant_idx = SELW'(c);
          found     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/round_robin_mux.sv
// Channel mux with fixed or round-robin selection feeding a one-word registered
// output stage with valid/ready handshake on both sides.
module round_robin_mux
  import mux_pkg::*;
#(
  parameter int  CHANNELS = 4,
  parameter int  WIDTH    = 8,
  localparam int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           s,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_sel
);

  logic [WIDTH-1:0]    in_words [CHANNELS];
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [SELW-1:0]     out_sel_q, out_sel_d;
  logic [SELW-1:0]     last_ptr_q, last_ptr_d;

  logic                load;
  logic                rr_mode;
  logic [CHANNELS-1:0] rr_grant;
  logic [SELW-1:0]     rr_idx;
  logic [CHANNELS-1:0] fixed_grant;
  logic [CHANNELS-1:0] grant;
  logic [CHANNELS-1:0] accept;
  logic [SELW-1:0]     sel_idx;
  logic [WIDTH-1:0]    sel_word;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign in_words[gi] = in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  rr_arbiter #(
    .CHANNELS (CHANNELS)
  ) u_arb (
    .req       (in_valid),
    .last_ptr  (last_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx)
  );

  // An out-of-range s matches no channel, so nothing is granted.
  always_comb begin
    fixed_grant = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (SELW'(c) == s) fixed_grant[c] = 1'b1;
    end
  end

  assign rr_mode  = (mode_e'(mode) == MODE_RR);
  assign load     = !reset && (!out_valid_q || out_ready);
  assign grant    = rr_mode ? rr_grant : fixed_grant;
  assign in_ready = load ? grant : '0;
  assign accept   = in_ready & in_valid;
  assign sel_idx  = rr_mode ? rr_idx : s;

  always_comb begin
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (SELW'(c) == sel_idx) sel_word = in_words[c];
    end
  end

  // A new word overwrites a departing one, so back-to-back transfers keep full rate.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    last_ptr_d  = last_ptr_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (|accept) begin
      out_valid_d = 1'b1;
      out_d       = sel_word;
      out_sel_d   = sel_idx;
      last_ptr_d  = sel_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sel_q   <= '0;
      last_ptr_q  <= SELW'(CHANNELS - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_round_robin_mux.sv
// Bench for round_robin_mux: directed vector table on a 4-channel instance, an
// out-of-range select on a 3-channel instance, and a randomised scoreboard on 5 channels.
module tb_round_robin_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [31:0] in4;
  logic [3:0]  v4, r4;
  logic        m4, ordy4, ov4;
  logic [1:0]  s4, os4;
  logic [7:0]  o4;

  logic [23:0] in3;
  logic [2:0]  v3, r3;
  logic        m3, ordy3, ov3;
  logic [1:0]  s3, os3;
  logic [7:0]  o3;

  logic [59:0] in5;
  logic [4:0]  v5, r5;
  logic        m5, ordy5, ov5;
  logic [2:0]  s5, os5;
  logic [11:0] o5;

  round_robin_mux #(.CHANNELS(4), .WIDTH(8)) dut4 (
    .clk(clk), .reset(reset), .in(in4), .in_valid(v4), .in_ready(r4), .mode(m4), .s(s4),
    .out(o4), .out_valid(ov4), .out_ready(ordy4), .out_sel(os4));

  round_robin_mux #(.CHANNELS(3), .WIDTH(8)) dut3 (
    .clk(clk), .reset(reset), .in(in3), .in_valid(v3), .in_ready(r3), .mode(m3), .s(s3),
    .out(o3), .out_valid(ov3), .out_ready(ordy3), .out_sel(os3));

  round_robin_mux #(.CHANNELS(5), .WIDTH(12)) dut5 (
    .clk(clk), .reset(reset), .in(in5), .in_valid(v5), .in_ready(r5), .mode(m5), .s(s5),
    .out(o5), .out_valid(ov5), .out_ready(ordy5), .out_sel(os5));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [1:0] s;
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_ov;
    logic       chk_data;
    logic [7:0] exp_out;
    logic [1:0] exp_sel;
  } vec_t;

  function automatic vec_t mk(input int mode, input int s, input int valid, input int rdy,
                              input int er, input int eov, input int chk, input int eout,
                              input int esel);
    vec_t v;
    v.mode      = 1'(mode);
    v.s         = 2'(s);
    v.valid     = 4'(valid);
    v.rdy       = 1'(rdy);
    v.exp_ready = 4'(er);
    v.exp_ov    = 1'(eov);
    v.chk_data  = 1'(chk);
    v.exp_out   = 8'(eout);
    v.exp_sel   = 2'(esel);
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int n);
    @(negedge clk);
    m4 = v.mode; s4 = v.s; v4 = v.valid; ordy4 = v.rdy;
    ordy3 = n[0];
    #1;
    check($sformatf("vec%0d in_ready", n), r4, v.exp_ready);
    check($sformatf("vec%0d c3 in_ready", n), r3, 0);
    @(posedge clk); #1;
    check($sformatf("vec%0d out_valid", n), ov4, v.exp_ov);
    if (v.chk_data) begin
      check($sformatf("vec%0d out", n), o4, v.exp_out);
      check($sformatf("vec%0d out_sel", n), os4, v.exp_sel);
    end
    check($sformatf("vec%0d c3 out_valid", n), ov3, 0);
    $display("[TB] vec %0d mode=%0d s=%0d valid=%h rdy=%0d -> in_ready=%h out_valid=%0d out=%h sel=%0d",
             n, v.mode, v.s, v.valid, v.rdy, r4, ov4, o4, os4);
  endtask

  vec_t vecs[22];

  typedef struct {
    int          sel;
    logic [11:0] d;
  } word_t;

  word_t       sb[$];
  logic [11:0] data_m [5];
  bit          vld_m [5];
  int          wait_m [5];
  int          last_m;

  initial begin
    reset = 1'b1;
    in4 = 32'h44332211; v4 = '0; m4 = 1'b0; s4 = '0; ordy4 = 1'b0;
    in3 = 24'h332211;   v3 = 3'b111; m3 = 1'b0; s3 = 2'd3; ordy3 = 1'b0;
    in5 = '0; v5 = '0; m5 = 1'b0; s5 = '0; ordy5 = 1'b0;

    // Round-robin rotation, single requester, no-request hold, fixed-mode stall,
    // fixed-mode pointer update, grant without request, and stall in round-robin mode.
    vecs[0]  = mk(1, 0, 4'hF, 1, 4'b0001, 1, 1, 8'h11, 0);
    vecs[1]  = mk(1, 0, 4'hF, 1, 4'b0010, 1, 1, 8'h22, 1);
    vecs[2]  = mk(1, 0, 4'hF, 1, 4'b0100, 1, 1, 8'h33, 2);
    vecs[3]  = mk(1, 0, 4'hF, 1, 4'b1000, 1, 1, 8'h44, 3);
    vecs[4]  = mk(1, 0, 4'hF, 1, 4'b0001, 1, 1, 8'h11, 0);
    vecs[5]  = mk(1, 0, 4'h4, 1, 4'b0100, 1, 1, 8'h33, 2);
    vecs[6]  = mk(1, 0, 4'h4, 1, 4'b0100, 1, 1, 8'h33, 2);
    vecs[7]  = mk(1, 0, 4'h4, 1, 4'b0100, 1, 1, 8'h33, 2);
    vecs[8]  = mk(1, 0, 4'h0, 1, 4'b0000, 0, 0, 8'h00, 0);
    vecs[9]  = mk(1, 0, 4'hF, 1, 4'b1000, 1, 1, 8'h44, 3);
    vecs[10] = mk(1, 0, 4'hF, 1, 4'b0001, 1, 1, 8'h11, 0);
    vecs[11] = mk(0, 3, 4'hF, 0, 4'b0000, 1, 1, 8'h11, 0);
    vecs[12] = mk(0, 3, 4'hF, 1, 4'b1000, 1, 1, 8'h44, 3);
    vecs[13] = mk(0, 3, 4'hF, 0, 4'b0000, 1, 1, 8'h44, 3);
    vecs[14] = mk(0, 3, 4'hF, 0, 4'b0000, 1, 1, 8'h44, 3);
    vecs[15] = mk(0, 3, 4'hF, 1, 4'b1000, 1, 1, 8'h44, 3);
    vecs[16] = mk(1, 0, 4'hF, 1, 4'b0001, 1, 1, 8'h11, 0);
    vecs[17] = mk(0, 1, 4'h8, 1, 4'b0010, 0, 0, 8'h00, 0);
    vecs[18] = mk(0, 1, 4'h8, 0, 4'b0010, 0, 0, 8'h00, 0);
    vecs[19] = mk(1, 0, 4'h8, 1, 4'b1000, 1, 1, 8'h44, 3);
    vecs[20] = mk(1, 0, 4'h2, 0, 4'b0000, 1, 1, 8'h44, 3);
    vecs[21] = mk(1, 0, 4'h2, 1, 4'b0010, 1, 1, 8'h22, 1);

    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset in_ready", r4, 0);
    @(negedge clk);
    check("reset out_valid", ov4, 0);
    check("reset out", o4, 0);
    check("reset out_sel", os4, 0);
    check("reset c5 out_valid", ov5, 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) apply_vec(vecs[i], i);

    // Reset while a word is held and stalled.
    @(negedge clk);
    reset = 1'b1; m4 = 1'b1; v4 = 4'hF; ordy4 = 1'b0;
    #1;
    check("rst-mid in_ready", r4, 0);
    @(posedge clk); #1;
    check("rst-mid out_valid", ov4, 0);
    check("rst-mid out", o4, 0);
    check("rst-mid out_sel", os4, 0);
    @(negedge clk);
    reset = 1'b0; ordy4 = 1'b1;
    #1;
    check("post-rst in_ready", r4, 4'b0001);
    @(posedge clk); #1;
    check("post-rst out", o4, 8'h11);
    check("post-rst out_sel", os4, 0);
    $display("[TB] reset mid-transfer: first grant sel=%0d out=%h", os4, o4);
    v4 = '0;

    // Randomised run on the 5-channel instance, starting from reset.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_m = 4;
    for (int c = 0; c < 5; c++) begin
      vld_m[c] = 1'b0; data_m[c] = '0; wait_m[c] = 0;
    end

    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic [4:0] exp_r;
      int         g;
      bit         load_m, in_x, out_x;
      int         worst;
      if (cyc != 0) @(negedge clk);
      for (int c = 0; c < 5; c++) begin
        if (!vld_m[c] && ($urandom_range(0, 1) == 1)) begin
          vld_m[c]  = 1'b1;
          data_m[c] = 12'($urandom_range(0, 4095));
        end
        v5[c] = vld_m[c];
        in5[c*12 +: 12] = data_m[c];
      end
      m5    = (cyc < 8000) ? 1'b1 : 1'($urandom_range(0, 1));
      s5    = 3'($urandom_range(0, 7));
      ordy5 = ($urandom_range(0, 9) < 7);
      #1;

      check("rnd out_valid", ov5, (sb.size() != 0));
      if (sb.size() != 0) begin
        check("rnd out", o5, sb[0].d);
        check("rnd out_sel", os5, sb[0].sel);
      end

      load_m = (sb.size() == 0) || ordy5;
      g = -1;
      if (load_m) begin
        if (m5) begin
          for (int k = 1; k <= 5; k++) begin
            if (g < 0 && vld_m[(last_m + k) % 5]) g = (last_m + k) % 5;
          end
        end else if (s5 < 5) begin
          g = s5;
        end
      end
      exp_r = '0;
      if (g >= 0) exp_r[g] = 1'b1;
      check("rnd in_ready", r5, exp_r);
      check("rnd onehot", $onehot0(r5), 1);

      out_x = (sb.size() != 0) && ordy5;
      in_x  = (g >= 0) && vld_m[g];
      if (out_x) void'(sb.pop_front());
      worst = 0;
      if (in_x) begin
        sb.push_back('{sel: g, d: data_m[g]});
        last_m = g;
        if (m5) begin
          for (int c = 0; c < 5; c++) begin
            if (c != g && vld_m[c]) wait_m[c]++;
            if (wait_m[c] > worst) worst = wait_m[c];
          end
        end
        wait_m[g] = 0;
        vld_m[g]  = 1'b0;
      end
      if (!m5) begin
        for (int c = 0; c < 5; c++) wait_m[c] = 0;
      end
      check("rnd starvation", (worst > 5), 0);
      if (cyc % 1000 == 0)
        $display("[TB] rnd cycle %0d mode=%0d valid=%b in_ready=%b out_valid=%0d out=%h sel=%0d",
                 cyc, m5, v5, r5, ov5, o5, os5);
    end

    // Drain: with no new requests the held word must leave and out_valid must drop.
    @(negedge clk);
    v5 = '0; ordy5 = 1'b1;
    @(posedge clk); #1;
    check("drain out_valid", ov5, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
